// File: rtl/aes_pkg.sv
// aes_pkg: FSM states, round count, inverse S-box and inverse byte transforms for AES decryption
package aes_pkg;
  localparam int NR_AES128 = 10;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} dec_state_e;
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[8*(4*((c+r)%4)+r) +: 8] = s[8*(4*c+r) +: 8];
    return res;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int n = 0; n < 16; n++) res[8*n +: 8] = INV_SBOX[s[8*n +: 8]];
    return res;
  endfunction
endpackage

// File: rtl/inv_mixColumns.sv
// inv_mixColumns: combinational AES InvMixColumns over four 32-bit columns
module inv_mixColumns (
  input  logic [127:0] data,
  output logic [127:0] result
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a3, a2, a1, a0} = data[32*c +: 32];
    assign result[32*c +: 32] = {
      mul(a0, 4'd11) ^ mul(a1, 4'd13) ^ mul(a2, 4'd9)  ^ mul(a3, 4'd14),
      mul(a0, 4'd13) ^ mul(a1, 4'd9)  ^ mul(a2, 4'd14) ^ mul(a3, 4'd11),
      mul(a0, 4'd9)  ^ mul(a1, 4'd14) ^ mul(a2, 4'd11) ^ mul(a3, 4'd13),
      mul(a0, 4'd14) ^ mul(a1, 4'd11) ^ mul(a2, 4'd13) ^ mul(a3, 4'd9)};
  end
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES-128 decryption, one round per clock, round keys fetched by index
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  dec_state_e state, state_nxt;
  logic [3:0] round_ctr;
  logic [127:0] state_reg, core, mixed;
  assign core = inv_sub_bytes(inv_shift_rows(state_reg)) ^ rk;
  inv_mixColumns u_inv_mix (.data(core), .result(mixed));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'(NR);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = round_ctr;
        if (round_ctr == 4'd1) state_nxt = FINAL;
      end
      FINAL: begin
        rk_idx    = 4'd0;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign plaintext = state_reg;
  // Final round skips InvMixColumns, so it stores the pre-mix value.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_reg <= '0;
      round_ctr <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state_reg <= ciphertext ^ rk;
          round_ctr <= 4'(NR - 1);
        end
        ROUND: begin
          state_reg <= mixed;
          round_ctr <= round_ctr - 4'd1;
        end
        FINAL: state_reg <= core;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: randomized and known-answer checks against a byte-level AES reference model
module tb_aes_dec_round_ctrl;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ciphertext, rk, plaintext;
  logic [3:0] rk_idx;
  int checks = 0, errors = 0;
  logic [127:0] rks [11];
  logic [7:0] sb [256];
  logic [7:0] inv_sb [256];
  logic [127:0] c1_ct, c1_pt;

  always #5 clk = ~clk;
  assign rk = (rk_idx <= 4'd10) ? rks[rk_idx] : 128'h0;

  aes_dec_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Forward S-box from GF(2^8) inversion plus affine map; inverse S-box by table inversion.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x] = s;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] swap(input logic [127:0] h);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = h[127-8*n -: 8];
    return r;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = '{sb[w[i-1][1]] ^ rcon, sb[w[i-1][2]], sb[w[i-1][3]], sb[w[i-1][0]]};
        rcon = gmul(rcon, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 11; r++) for (int n = 0; n < 16; n++) rks[r][8*n +: 8] = w[4*r + n/4][n%4];
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [4];
    logic [127:0] r;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int n = 0; n < 16; n++) s[n] = ct[8*n +: 8] ^ rks[10][8*n +: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++) for (int q = 0; q < 4; q++) t[4*((c+q)%4)+q] = inv_sb[s[4*c+q]];
      for (int n = 0; n < 16; n++) t[n] ^= rks[rd][8*n +: 8];
      if (rd == 0) s = t;
      else for (int c = 0; c < 4; c++) for (int i = 0; i < 4; i++) begin
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(t[4*c+j], m[(j-i+4)%4]);
        s[4*c+i] = acc;
      end
    end
    for (int n = 0; n < 16; n++) r[8*n +: 8] = s[n];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic [127:0] ct);
    in_valid = 1'b1;
    ciphertext = ct;
    tick();
    in_valid = 1'b0;
    ciphertext = rand128();
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      ok = out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ciphertext = '0;
    #2;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: in_ready/out_valid/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (rk_idx !== 4'd10) begin
      errors++;
      $display("FAIL reset_rk_idx: got %0d expected 10", rk_idx);
    end
    checks++;
    if (plaintext !== 128'h0) begin
      errors++;
      $display("FAIL reset_plaintext: got %h expected 0", plaintext);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_c1();
    checks++;
    if (rk_idx !== 4'd10 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL c1_idle: rk_idx=%0d in_ready=%b expected 10 1", rk_idx, in_ready);
    end
    accept(c1_ct);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL c1_first_accept: busy=%b expected 1", busy);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rk_idx !== 4'(9 - k) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL c1_seq step %0d: rk_idx=%0d out_valid=%b in_ready=%b expected %0d 0 0",
                 k, rk_idx, out_valid, in_ready, 9 - k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL c1_latency: out_valid=%b expected 1 ten cycles after accept", out_valid);
    end
    checks++;
    if (plaintext !== c1_pt) begin
      errors++;
      $display("FAIL c1_plaintext: got %h expected %h", plaintext, c1_pt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (rk_idx !== 4'd10 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL c1_return_idle: rk_idx=%0d in_ready=%b out_valid=%b busy=%b expected 10 1 0 0",
               rk_idx, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    accept(c1_ct);
    wait_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b expected 1 within 20 cycles", out_valid);
    end
    in_valid = 1'b1;
    ciphertext = rand128();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (plaintext !== c1_pt || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: plaintext=%h in_ready=%b out_valid=%b expected %h 0 1",
                 i, plaintext, in_ready, out_valid, c1_pt);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b busy=%b out_valid=%b expected 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int outs, cyc;
    outs = 0;
    cyc = 0;
    in_valid = 1'b1;
    ciphertext = c1_ct;
    out_ready = 1'b1;
    while (outs < 2 && cyc < 40) begin
      if (in_valid && in_ready) acc.push_back(cyc);
      if (out_valid) begin
        outs++;
        checks++;
        if (plaintext !== c1_pt) begin
          errors++;
          $display("FAIL b2b_plaintext %0d: got %h expected %h", outs, plaintext, c1_pt);
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (outs != 2) begin
      errors++;
      $display("FAIL b2b_outputs: got %0d outputs expected 2 within 40 cycles", outs);
    end
    checks++;
    if (acc.size() < 2 || acc[1] - acc[0] != 12) begin
      errors++;
      $display("FAIL b2b_spacing: %0d accepts, spacing %0d expected 12",
               acc.size(), acc.size() >= 2 ? acc[1] - acc[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, ok;
    accept(c1_ct);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd10 || plaintext !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b rk_idx=%0d plaintext=%h expected 1 0 0 10 0",
               in_ready, out_valid, busy, rk_idx, plaintext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= out_valid;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_discard: out_valid=1 seen after reset, expected 0");
    end
    accept(c1_ct);
    wait_valid(20, ok);
    checks++;
    if (!ok || plaintext !== c1_pt) begin
      errors++;
      $display("FAIL mid_reset_fresh: out_valid=%b plaintext=%h expected 1 %h", out_valid, plaintext, c1_pt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    bit ok;
    logic [127:0] exp_pt;
    for (int r = 0; r < 11; r++) rks[r] = '0;
    exp_pt = model_dec(128'h0);
    accept(128'h0);
    wait_valid(20, ok);
    checks++;
    if (!ok || plaintext !== exp_pt) begin
      errors++;
      $display("FAIL zero_block: out_valid=%b plaintext=%h expected 1 %h", out_valid, plaintext, exp_pt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    logic [127:0] ct, exp_pt;
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < 11; r++) rks[r] = rand128();
      ct = rand128();
      exp_pt = model_dec(ct);
      accept(ct);
      wait_valid(20, ok);
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (!ok || out_valid !== 1'b1 || plaintext !== exp_pt) begin
        errors++;
        $display("FAIL random_block %0d: out_valid=%b plaintext=%h expected 1 %h", b, out_valid, plaintext, exp_pt);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    build_tables();
    expand_key(swap(128'h000102030405060708090a0b0c0d0e0f));
    c1_ct = swap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c1_pt = swap(128'h00112233445566778899aabbccddeeff);
    test_reset();
    test_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
